// File: rtl/curve_lut_pkg.sv
// Shared types and constants for the programmable tone-curve engine.
package curve_lut_pkg;

    localparam int DW_DEFAULT = 8;
    localparam int LUT_DEPTH  = 2**DW_DEFAULT;

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_IDLE    = 2'd1,
        ST_PENDING = 2'd2
    } state_t;

endpackage

// File: rtl/curve_lut_bank.sv
// One curve bank: 2**DW x DW RAM with a single write port and a registered read port.
module curve_lut_bank
    import curve_lut_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          i_wr_en,
    input  logic [DW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic [DW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_data
);

    logic [DW-1:0] r_mem [2**DW];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        o_rd_data <= r_mem[i_rd_addr];
    end

endmodule

// File: rtl/curve_lut_ctrl.sv
// Ping-pong curve LUT: pixels are looked up in the active bank while the shadow bank
// is reprogrammed; banks swap only on a frame-sync assertion edge after a commit.
module curve_lut_ctrl
    import curve_lut_pkg::*;
#(
    parameter int DW        = DW_DEFAULT,
    parameter bit VSYNC_POL = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pre_vsync,
    input  logic          pre_href,
    input  logic [DW-1:0] pre_data,
    output logic          post_vsync,
    output logic          post_href,
    output logic [DW-1:0] post_data,
    input  logic          cfg_wr_en,
    input  logic [DW-1:0] cfg_addr,
    input  logic [DW-1:0] cfg_wdata,
    output logic          cfg_wr_ready,
    input  logic          cfg_commit,
    output logic          cfg_pending,
    output logic          active_bank,
    output logic          init_done
);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [DW-1:0] r_init_cnt;
    logic          r_init_done;
    logic          r_active_bank;

    logic          r_vsync_p1;
    logic          r_href_p1;
    logic [DW-1:0] r_data_p1;
    logic          r_sel_p1;
    logic          r_bypass_p1;

    logic          w_init_we;
    logic          w_init_last;
    logic          w_frame_edge;
    logic          w_cfg_we;
    logic [DW-1:0] w_wr_addr;
    logic [DW-1:0] w_wr_data;
    logic [1:0]    w_bank_we;
    logic [DW-1:0] w_rd_data [2];

    assign w_init_last  = &r_init_cnt;
    // Edge is judged against the stage-1 vsync register, so the first active cycle counts.
    assign w_frame_edge = (r_vsync_p1 != VSYNC_POL) && (pre_vsync == VSYNC_POL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT:    if (w_init_last)  w_state_nxt = ST_IDLE;
            ST_IDLE:    if (cfg_commit)   w_state_nxt = ST_PENDING;
            ST_PENDING: if (w_frame_edge) w_state_nxt = ST_IDLE;
            default:                      w_state_nxt = ST_INIT;
        endcase
    end

    always_comb begin
        w_init_we    = 1'b0;
        cfg_wr_ready = 1'b0;
        cfg_pending  = 1'b0;
        case (r_state)
            ST_INIT:    w_init_we    = 1'b1;
            ST_IDLE:    cfg_wr_ready = 1'b1;
            ST_PENDING: cfg_pending  = 1'b1;
            default:    w_init_we    = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_init_cnt    <= '0;
            r_init_done   <= 1'b0;
            r_active_bank <= 1'b0;
        end else begin
            if (w_init_we) begin
                r_init_cnt <= r_init_cnt + 1'b1;
            end
            if (w_init_we && w_init_last) begin
                r_init_done <= 1'b1;
            end
            if ((r_state == ST_PENDING) && w_frame_edge) begin
                r_active_bank <= ~r_active_bank;
            end
        end
    end

    // Init loads identity into both banks; afterwards cfg writes reach only the shadow bank.
    assign w_cfg_we     = cfg_wr_en & cfg_wr_ready;
    assign w_wr_addr    = w_init_we ? r_init_cnt : cfg_addr;
    assign w_wr_data    = w_init_we ? r_init_cnt : cfg_wdata;
    assign w_bank_we[0] = w_init_we | (w_cfg_we &  r_active_bank);
    assign w_bank_we[1] = w_init_we | (w_cfg_we & ~r_active_bank);

    for (genvar g = 0; g < 2; g++) begin : gen_bank
        curve_lut_bank #(
            .DW(DW)
        ) u_bank (
            .clk       (clk),
            .i_wr_en   (w_bank_we[g]),
            .i_wr_addr (w_wr_addr),
            .i_wr_data (w_wr_data),
            .i_rd_addr (pre_data),
            .o_rd_data (w_rd_data[g])
        );
    end

    // Stage 1: bank read issued; bank select captured with it so a swap cannot split a pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vsync_p1  <= 1'b0;
            r_href_p1   <= 1'b0;
            r_data_p1   <= '0;
            r_sel_p1    <= 1'b0;
            r_bypass_p1 <= 1'b1;
        end else begin
            r_vsync_p1  <= pre_vsync;
            r_href_p1   <= pre_href;
            r_data_p1   <= pre_data;
            r_sel_p1    <= r_active_bank;
            r_bypass_p1 <= ~r_init_done;
        end
    end

    // Stage 2: output register, blanked outside active line time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            post_vsync <= 1'b0;
            post_href  <= 1'b0;
            post_data  <= '0;
        end else begin
            post_vsync <= r_vsync_p1;
            post_href  <= r_href_p1;
            if (!r_href_p1) begin
                post_data <= '0;
            end else if (r_bypass_p1) begin
                post_data <= r_data_p1;
            end else begin
                post_data <= w_rd_data[r_sel_p1];
            end
        end
    end

    assign active_bank = r_active_bank;
    assign init_done   = r_init_done;

endmodule
